// File: rtl/ram_1port_resp.sv
// Single-port RAM responder: self-clears on reset, then services reads and writes.
// Also counts accepted accesses and flags out-of-range addresses (sticky).
module ram_1port_resp #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic              addr_err
);

    localparam int STAGES = RD_LATENCY;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                ready, legal, wr_go, rd_go, err_hit;
    logic [DATA_W-1:0]   rd_dat;

    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0][DATA_W-1:0]  dat_pipe;

    logic [15:0]         wr_cnt_q, rd_cnt_q;
    logic                addr_err_q;

    // Clear sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_INIT) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                state_d = S_READY;
                ptr_d   = '0;
            end
        end
    end

    assign ready   = (state_q == S_READY);
    assign legal   = {1'b0, address} < (ADDR_W + 1)'(DEPTH);
    assign wr_go   = ready & wren & legal;
    assign rd_go   = ready & rden;
    assign err_hit = ready & (wren | rden) & ~legal;

    // Same-cycle write wins over stored data; illegal reads return zero.
    always_comb begin
        rd_dat = '0;
        if (legal)
            rd_dat = wren ? data : mem[address];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == S_INIT)
                mem[ptr_q] <= '0;
            else if (wr_go)
                mem[address] <= data;
        end
    end

    // Read pipeline: stage 0 captures at the sampling edge, each later stage adds a clock.
    // Data stages only advance on valid so q holds its last value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_go};
            if (rd_go)
                dat_pipe[0] <= rd_dat;
            for (int s = 1; s <= STAGES; s++) begin
                if (vld_pipe[s-1])
                    dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            if (wr_go && wr_cnt_q != 16'hFFFF)
                wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd_go && legal && rd_cnt_q != 16'hFFFF)
                rd_cnt_q <= rd_cnt_q + 16'd1;
            if (err_hit)
                addr_err_q <= 1'b1;
        end
    end

    assign q        = dat_pipe[STAGES];
    assign q_valid  = vld_pipe[STAGES];
    assign busy     = ~ready;
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_ram_1port_resp.sv
// Directed bench for ram_1port_resp: instance A (DEPTH 32, latency 1) and
// instance B (DEPTH 20, latency 2) exercised one after the other.
module tb_ram_1port_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wren_a, rden_a, qv_a, busy_a, err_a;
    logic [4:0] addr_a;
    logic [7:0] data_a, q_a;
    logic [15:0] wrc_a, rdc_a;

    logic       rst_b, wren_b, rden_b, qv_b, busy_b, err_b;
    logic [4:0] addr_b;
    logic [7:0] data_b, q_b;
    logic [15:0] wrc_b, rdc_b;

    ram_1port_resp #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst_a), .address(addr_a), .data(data_a), .wren(wren_a),
        .rden(rden_a), .q(q_a), .q_valid(qv_a), .busy(busy_a), .wr_cnt(wrc_a),
        .rd_cnt(rdc_a), .addr_err(err_a)
    );

    ram_1port_resp #(.ADDR_W(5), .DATA_W(8), .DEPTH(20), .RD_LATENCY(2)) u_b (
        .clk(clk), .rst(rst_b), .address(addr_b), .data(data_b), .wren(wren_b),
        .rden(rden_b), .q(q_b), .q_valid(qv_b), .busy(busy_b), .wr_cnt(wrc_b),
        .rd_cnt(rdc_b), .addr_err(err_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_a = 1; wren_a = 0; rden_a = 0; addr_a = 0; data_a = 0;
        rst_b = 1; wren_b = 0; rden_b = 0; addr_b = 0; data_b = 0;
        tick(); tick();

        chk("a_rst_q", q_a, 0);
        chk("a_rst_qv", qv_a, 0);
        chk("a_rst_busy", busy_a, 1);
        chk("a_rst_wr", wrc_a, 0);
        chk("a_rst_rd", rdc_a, 0);
        chk("a_rst_err", err_a, 0);
        chk("b_rst_busy", busy_b, 1);

        // Requests during the clear must be ignored
        rst_a = 0; rst_b = 0;
        wren_a = 1; rden_a = 1; addr_a = 0; data_a = 8'hFF;
        n = 0;
        while (busy_a && n < 100) begin
            chk("a_init_qv", qv_a, 0);
            n++;
            tick();
        end
        wren_a = 0; rden_a = 0;
        chk("a_busy_len", n, 32);
        chk("a_init_wr", wrc_a, 0);
        chk("a_init_rd", rdc_a, 0);
        chk("a_init_qv_end", qv_a, 0);

        // First read: address 5 is zero after the clear
        rden_a = 1; addr_a = 5;
        tick();
        rden_a = 0;
        chk("a_rd5_cnt", rdc_a, 1);
        chk("a_rd5_qv_early", qv_a, 0);
        tick();
        chk("a_rd5_qv", qv_a, 1);
        chk("a_rd5_q", q_a, 0);
        tick();
        chk("a_rd5_qv_pulse", qv_a, 0);

        // Address 0 was written with FF while busy; must read zero
        rden_a = 1; addr_a = 0;
        tick();
        rden_a = 0;
        tick();
        chk("a_rd0_qv", qv_a, 1);
        chk("a_rd0_q", q_a, 0);

        for (int a = 0; a < 32; a++) begin
            wren_a = 1; addr_a = 5'(a); data_a = 8'(a);
            tick();
        end
        wren_a = 0;
        chk("a_fill_wr", wrc_a, 32);

        for (int i = 0; i <= 32; i++) begin
            if (i < 32) begin
                rden_a = 1; addr_a = 5'(i);
            end else begin
                rden_a = 0;
            end
            tick();
            if (i == 0)
                chk("a_rb_qv0", qv_a, 0);
            else begin
                chk("a_rb_qv", qv_a, 1);
                chk("a_rb_q", q_a, 32'(i - 1));
            end
        end
        tick();
        chk("a_rb_qv_end", qv_a, 0);
        chk("a_rb_q_hold", q_a, 8'h1F);
        chk("a_rb_rd", rdc_a, 34);
        chk("a_rb_wr", wrc_a, 32);

        // Simultaneous write+read returns the new data
        wren_a = 1; addr_a = 3; data_a = 8'h11;
        tick();
        rden_a = 1; data_a = 8'hA5;
        tick();
        wren_a = 0; rden_a = 0;
        chk("a_wt_wr", wrc_a, 34);
        chk("a_wt_rd", rdc_a, 35);
        tick();
        chk("a_wt_qv", qv_a, 1);
        chk("a_wt_q", q_a, 8'hA5);
        rden_a = 1; addr_a = 3;
        tick();
        rden_a = 0;
        tick();
        chk("a_wt_re_qv", qv_a, 1);
        chk("a_wt_re_q", q_a, 8'hA5);
        chk("a_wt_re_rd", rdc_a, 36);

        // Write counter saturates at FFFF
        wren_a = 1; addr_a = 9; data_a = 8'h77;
        repeat (65540) tick();
        wren_a = 0;
        chk("a_sat_wr", wrc_a, 16'hFFFF);
        chk("a_sat_rd", rdc_a, 36);

        // Instance B: latency 2, DEPTH 20
        chk("b_ready", busy_b, 0);
        chk("b_err0", err_b, 0);
        wren_b = 1; addr_b = 7; data_b = 8'h3C;
        tick();
        wren_b = 0;
        chk("b_wr1", wrc_b, 1);
        rden_b = 1; addr_b = 7;
        tick();
        rden_b = 0;
        chk("b_rd_cnt", rdc_b, 1);
        chk("b_lat_qv_e1", qv_b, 0);
        tick();
        chk("b_lat_qv_e2", qv_b, 0);
        tick();
        chk("b_lat_qv", qv_b, 1);
        chk("b_lat_q", q_b, 8'h3C);
        tick();
        chk("b_lat_qv_pulse", qv_b, 0);
        chk("b_lat_q_hold", q_b, 8'h3C);

        // Out-of-range read: returns zero, flags error, no count
        rden_b = 1; addr_b = 25;
        tick();
        rden_b = 0;
        chk("b_ill_err", err_b, 1);
        chk("b_ill_rd", rdc_b, 1);
        tick(); tick();
        chk("b_ill_qv", qv_b, 1);
        chk("b_ill_q", q_b, 0);
        tick();
        chk("b_ill_sticky", err_b, 1);
        wren_b = 1; addr_b = 25; data_b = 8'h55;
        tick();
        wren_b = 0;
        chk("b_ill_wr", wrc_b, 1);

        // Reset one cycle after launching a read flushes it
        rden_b = 1; addr_b = 7;
        tick();
        rden_b = 0; rst_b = 1;
        tick();
        rst_b = 0;
        chk("b_mid_qv", qv_b, 0);
        chk("b_mid_q", q_b, 0);
        chk("b_mid_wr", wrc_b, 0);
        chk("b_mid_rd", rdc_b, 0);
        chk("b_mid_busy", busy_b, 1);
        chk("b_mid_err", err_b, 0);
        n = 0;
        while (busy_b && n < 100) begin
            chk("b_mid_init_qv", qv_b, 0);
            n++;
            tick();
        end
        chk("b_busy_len", n, 20);
        rden_b = 1; addr_b = 7;
        tick();
        rden_b = 0;
        tick(); tick();
        chk("b_clr_qv", qv_b, 1);
        chk("b_clr_q", q_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
